// File: rtl/parity_serializer.sv
`default_nettype none
// ============================================================================
// Module   : parity_serializer
// Purpose  : Parallel-to-serial transmitter with a parity bit at the end of
//            each frame. A DATA_W-bit word is taken over a valid/ready
//            handshake and sent LSB first, one bit per transferred beat. The
//            parity bit follows as the last beat (tx_last = 1).
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            in_data    - word to transmit, sampled on acceptance
//            in_valid   - in_data is valid
//            in_ready   - a word can be accepted this cycle (combinational)
//            tx_bit     - current serial bit
//            tx_valid   - tx_bit is valid
//            tx_last    - current beat is the parity bit
//            tx_ready   - downstream takes tx_bit this cycle
// Params   : DATA_W (>= 2) word width, ODD (0 = even, 1 = odd parity)
// Macro    : PARITY_SERIALIZER_START_BIT_EN - sends a '1' start bit before the
//            data bits of every frame. The parity does not cover this bit.
// Revision : 1.0 - initial release
// ============================================================================
module parity_serializer #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             c_ODD      = (ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef PARITY_SERIALIZER_START_BIT_EN
        S_START  = 2'd3,
`endif
        S_PARITY = 2'd2
    } state_t;

    // State entered when a word is accepted (from IDLE or back-to-back).
`ifdef PARITY_SERIALIZER_START_BIT_EN
    localparam state_t c_LOAD_STATE = S_START;
`else
    localparam state_t c_LOAD_STATE = S_DATA;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_q;

    // Held at 0 during reset so no word is taken while the block is cleared.
    // In PARITY a new word is only taken when the parity beat leaves, which
    // gives back-to-back frames without an idle bubble.
    assign in_ready = !rst &&
                      ((state_q == S_IDLE) || ((state_q == S_PARITY) && tx_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= c_LOAD_STATE;
                        shreg_q <= in_data;
                        cnt_q   <= '0;
                        par_q   <= (^in_data) ^ c_ODD;
                    end
                end
`ifdef PARITY_SERIALIZER_START_BIT_EN
                S_START: begin
                    if (tx_ready) begin
                        state_q <= S_DATA;
                    end
                end
`endif
                S_DATA: begin
                    if (tx_ready) begin
                        shreg_q <= shreg_q >> 1;
                        // Counter stops at the last bit index instead of wrapping.
                        if (cnt_q == c_LAST_BIT) begin
                            state_q <= S_PARITY;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_ready) begin
                        if (in_valid) begin
                            state_q <= c_LOAD_STATE;
                            shreg_q <= in_data;
                            cnt_q   <= '0;
                            par_q   <= (^in_data) ^ c_ODD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so they hold while
    // stalled and drop together with the asynchronous reset.
    always_comb begin
        tx_bit   = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        case (state_q)
`ifdef PARITY_SERIALIZER_START_BIT_EN
            S_START: begin
                tx_bit   = 1'b1;
                tx_valid = 1'b1;
            end
`endif
            S_DATA: begin
                tx_bit   = shreg_q[0];
                tx_valid = 1'b1;
            end
            S_PARITY: begin
                tx_bit   = par_q;
                tx_valid = 1'b1;
                tx_last  = 1'b1;
            end
            default: begin
                tx_bit   = 1'b0;
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_serializer
// Purpose  : Self-checking bench for parity_serializer. One instance uses even
//            parity and one uses odd parity. Expected beats are queued when a
//            word is accepted. A monitor per instance pops the queue on every
//            transferred beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_serializer;

`ifdef PARITY_SERIALIZER_START_BIT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data0 = 8'h00, in_data1 = 8'h00;
    logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic       in_ready0, in_ready1;
    logic       tx_bit0, tx_bit1, tx_valid0, tx_valid1, tx_last0, tx_last1;
    logic       tx_ready0 = 1'b1, tx_ready1 = 1'b1;

    int checks = 0;
    int errors = 0;

    // Each entry is {last, bit}.
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    parity_serializer #(.DATA_W(8), .ODD(0)) u_even (
        .clk(clk), .rst(rst),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .tx_bit(tx_bit0), .tx_valid(tx_valid0), .tx_last(tx_last0),
        .tx_ready(tx_ready0)
    );

    parity_serializer #(.DATA_W(8), .ODD(1)) u_odd (
        .clk(clk), .rst(rst),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .tx_bit(tx_bit1), .tx_valid(tx_valid1), .tx_last(tx_last1),
        .tx_ready(tx_ready1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int which, input logic [1:0] v);
        if (which == 0) q0.push_back(v);
        else            q1.push_back(v);
    endtask

    // Present a word and wait for acceptance; par is the hand-computed parity.
    task automatic send(input int which, input logic [7:0] d, input logic par);
        bit done = 1'b0;
        if (which == 0) begin in_data0 = d; in_valid0 = 1'b1; end
        else            begin in_data1 = d; in_valid1 = 1'b1; end
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if ((which == 0) ? in_ready0 : in_ready1) begin
`ifdef PARITY_SERIALIZER_START_BIT_EN
                push_exp(which, 2'b01);
`endif
                for (int i = 0; i < 8; i++) push_exp(which, {1'b0, d[i]});
                push_exp(which, {1'b1, par});
                @(posedge clk);
                #1;
                // Scramble the data lines: the frame must use the captured word.
                if (which == 0) begin in_valid0 = 1'b0; in_data0 = ~d; end
                else            begin in_valid1 = 1'b0; in_data1 = ~d; end
                done = 1'b1;
            end
        end
        if (!done) begin
            check("send_timeout", 0, 1);
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", int'(q0.size() + q1.size()), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid0 && tx_ready0) begin
            if (q0.size() == 0) check("even_unexpected_beat", 1, 0);
            else                check("even_beat", int'({tx_last0, tx_bit0}), int'(q0.pop_front()));
        end
        if (!rst && tx_valid1 && tx_ready1) begin
            if (q1.size() == 0) check("odd_unexpected_beat", 1, 0);
            else                check("odd_beat", int'({tx_last1, tx_bit1}), int'(q1.pop_front()));
        end
    end

    initial begin
        int cnt;
        // Reset state
        #1;
        check("rst_tx_valid", int'(tx_valid0), 0);
        check("rst_tx_bit", int'(tx_bit0), 0);
        check("rst_tx_last", int'(tx_last0), 0);
        check("rst_in_ready", int'(in_ready0), 0);
        check("rst_in_ready_odd", int'(in_ready1), 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready0), 1);

        // 0xA5 even parity: latency and frame length
        send(0, 8'hA5, 1'b0);
        check("latency_tx_valid", int'(tx_valid0), 1);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!tx_valid0) break;
            cnt++;
        end
        check("frame_len_A5", cnt, 9 + EXTRA);
        drain();

        // Parity sense
        send(0, 8'h07, 1'b1);
        send(1, 8'h07, 1'b0);
        drain();
        send(1, 8'h00, 1'b1);
        drain();

        // Back-to-back 0xFF then 0x01
        send(0, 8'hFF, 1'b0);
        fork
            send(0, 8'h01, 1'b1);
            begin
                int c = 0;
                for (int n = 0; n < 60; n++) begin
                    @(negedge clk);
                    if (!tx_valid0) break;
                    if (tx_last0) check("b2b_in_ready_in_parity", int'(in_ready0), 1);
                    c++;
                end
                check("b2b_consecutive_valid", c, 18 + 2 * EXTRA);
            end
        join
        drain();

        // Stall for 3 cycles on bit 2 of 0x3C
        send(0, 8'h3C, 1'b0);
        for (int i = 0; i < 2 + EXTRA; i++) begin @(posedge clk); #1; end
        tx_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_tx_bit", int'(tx_bit0), 1);
            check("stall_tx_valid", int'(tx_valid0), 1);
            check("stall_in_ready", int'(in_ready0), 0);
        end
        @(posedge clk);
        #1 tx_ready0 = 1'b1;
        drain();

        // Reset during bit 4 of 0x5A
        send(0, 8'h5A, 1'b0);
        for (int i = 0; i < 4 + EXTRA; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_valid", int'(tx_valid0), 0);
        check("midrst_in_ready", int'(in_ready0), 0);
        q0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_in_ready_after", int'(in_ready0), 1);
        send(0, 8'h81, 1'b0);
        drain();

        check("final_queue_even", int'(q0.size()), 0);
        check("final_queue_odd", int'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/parity_serializer.md
# parity_serializer

Parallel-to-serial parity transmitter that feeds the serial parity checker in the datapath. It accepts a DATA_W-bit word over a valid/ready handshake. It shifts the word out LSB first, one bit per accepted beat, then appends one parity bit. Bit-level backpressure comes from the downstream checker or link.

## Interface
- DATA_W, 8, word width in bits; legal values ≥ 2.
- ODD, 0, parity sense: 0 = even parity (ones in data + parity is even), 1 = odd parity.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to transmit; sampled on acceptance.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_bit  output  1  current serial bit.
- tx_valid  output  1  tx_bit is valid.
- tx_last  output  1  current beat is the parity bit (last bit of the frame).
- tx_ready  input  1  downstream accepts tx_bit this cycle.

## Operation
- States:
  - IDLE: no frame in flight.
  - DATA: shifting data bits.
  - PARITY: presenting the parity bit.
  - START: only with the macro; see Configuration.
- Word acceptance: a word is accepted when in_valid && in_ready at a rising edge.
- Beat transfer: a bit transfers when tx_valid && tx_ready at a rising edge.
- in_ready = (state==IDLE) || (state==PARITY && tx_ready). It is combinational, and it is 0 while rst is high.
- IDLE → DATA on acceptance:
  - load shift register with in_data;
  - load bit counter = 0;
  - load parity register = ^in_data ^ ODD.
- DATA:
  - tx_bit = shreg[0], tx_valid = 1, tx_last = 0.
  - On beat transfer: shift right one, counter += 1.
  - When counter == DATA_W-1 and the beat transfers, go to PARITY.
- PARITY:
  - tx_bit = parity register, tx_valid = 1, tx_last = 1.
  - On beat transfer with a new word accepted in the same cycle: go directly to DATA (or START) with the new word loaded. There is no idle bubble.
  - On beat transfer with no new word: go to IDLE.
- IDLE outputs: tx_valid = 0, tx_bit = 0, tx_last = 0.
- Stall: while tx_ready = 0, tx_bit, tx_valid, tx_last, state, counter and shift register all hold unchanged.
- tx_valid never deasserts mid-frame once raised.
- Counter width: $clog2(DATA_W). The counter never wraps past DATA_W-1; it resets on each load.
- in_data changes while not accepted are ignored. The frame in flight uses only the value captured at acceptance.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE;
  - shift register, counter and parity register = 0;
  - tx_bit = 0, tx_valid = 0, tx_last = 0, in_ready = 0.
- After rst falls, in_ready = 1 in the first cycle.
- Latency: a word accepted at edge N presents bit 0 on tx_bit after edge N (cycle N+1).
- Frame length with tx_ready held high: DATA_W + 1 cycles (DATA_W + 2 with the start bit).
- Sustained throughput with tx_ready high and words always available: one frame every DATA_W+1 cycles, with no gap cycles.
- Reset mid-frame: the frame is abandoned. tx_valid drops asynchronously, and no partial parity bit is ever emitted.
- Simultaneous events: in PARITY with tx_ready = 0, in_ready = 0, so a pending word waits. in_valid may be held with no timeout.

## Configuration
- PARITY_SERIALIZER_START_BIT_EN, when defined:
  - Acceptance enters START instead of DATA.
  - START presents tx_bit = 1, tx_valid = 1, tx_last = 0.
  - On beat transfer, START → DATA.
  - The parity bit does not cover the start bit.
  - Back-to-back from PARITY also enters START.
- When undefined: the START state and its logic are absent, and acceptance goes straight to DATA.

## Test plan
- ODD=0, DATA_W=8, in_data=0xA5, tx_ready=1 → tx_bit sequence 1,0,1,0,0,1,0,1 then parity 0 with tx_last=1; frame spans exactly 9 cycles.
- ODD=0, in_data=0x07 → parity bit 1. ODD=1, same word → parity bit 0. ODD=1, in_data=0x00 → parity bit 1.
- Back-to-back: 0xFF then 0x01 with in_valid held and tx_ready=1 → 18 consecutive tx_valid cycles; parity bits 0 then 1; in_ready pulses in each PARITY cycle.
- Stall: in_data=0x3C, tx_ready low for 3 cycles during bit 2 → tx_bit holds 1 and counter holds; full sequence 0,0,1,1,1,1,0,0,parity 0 is still delivered intact.
- Reset mid-frame: assert rst during bit 4 of 0x5A → tx_valid=0 immediately; after release, next word 0x81 produces a clean frame 1,0,0,0,0,0,0,1, parity 0.
- With PARITY_SERIALIZER_START_BIT_EN: in_data=0xA5 → 1, then 1,0,1,0,0,1,0,1, then 0; 10 cycles.
